// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, runs the imem request handshake and
// feeds IF/ID, discarding responses that belong to a redirected (wrong-path) fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_id_load,
    output logic        if_flush
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] pending_target, pending_next;
    logic            redirect;
    logic [XLEN-1:0] target;

    // Branch outranks jump; targets are forced word aligned.
    assign redirect = branch_taken | jump;
    assign target   = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc             <= RESET_PC & ALIGN_MASK;
            pending_target <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            pending_target <= pending_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        pending_next   = pending_target;
        imem_req       = 1'b0;
        imem_addr      = pc;
        if_pc          = pc;
        if_instruction = NOP_INSTR;
        if_id_load     = 1'b0;
        if_flush       = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if_flush = 1'b1;
                    // An unanswered request pins the address; remember where to go.
                    if (imem_ready) begin
                        pc_next = target;
                    end else begin
                        pending_next = target;
                        state_next   = DISCARD;
                    end
                end else if (!stall && imem_ready) begin
                    if_id_load     = 1'b1;
                    if_instruction = imem_rdata;
                    pc_next        = XLEN'(pc + PC_STEP);
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if_flush     = 1'b1;
                    pending_next = target;
                end
                // The wrong-path response is dropped; the newest redirect wins.
                if (imem_ready) begin
                    pc_next    = redirect ? target : pending_target;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage controller for the pipelined core. It owns the program counter, drives the instruction-memory request handshake, and produces the `if_pc`, `if_instruction`, `if_id_load` and `if_flush` values consumed by the IF/ID pipeline register. It applies stall and redirect requests from the hazard, ID (jump) and EX (branch) logic. It discards any memory response that belongs to a wrong-path fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: value driven on `if_instruction` when no valid instruction is presented.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit request: hold PC and IF/ID contents.
- `jump`  in  1  ID-stage jump redirect.
- `jump_target`  in  32  jump destination.
- `branch_taken`  in  1  EX-stage taken-branch redirect.
- `branch_target`  in  32  branch destination.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory response valid this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1.
- `if_pc`  out  32  PC of the presented instruction.
- `if_instruction`  out  32  instruction to IF/ID.
- `if_id_load`  out  1  IF/ID load enable.
- `if_flush`  out  1  IF/ID flush.

## Operation
- State: `pc[31:0]`, `state`, `pending_target[31:0]`. States: IDLE, FETCH, DISCARD.
- Reset asserted (`reset`=0), at any time including mid-handshake:
  - state=IDLE, pc=`RESET_PC`, pending_target=0.
  - `imem_req`=0, `if_id_load`=0, `if_flush`=0, `if_instruction`=`NOP_INSTR`.
  - `if_pc`=`imem_addr`=`RESET_PC`.
- IDLE: `imem_req`=0. Next state is FETCH unconditionally; there is one idle cycle after reset release.
- FETCH: `imem_req`=1, `imem_addr`=pc. Next-PC priority, highest first:
  1. `branch_taken`: pc←{branch_target[31:2],2'b00}; `if_flush`=1, `if_id_load`=0. If `imem_ready`=0, pending_target←target and go to DISCARD.
  2. `jump`: same as branch_taken, using jump_target.
  3. `stall`: pc held, `if_id_load`=0. The response (if any) is dropped and the same address is re-requested next cycle.
  4. `imem_ready`=1: `if_instruction`=`imem_rdata`, `if_pc`=pc, `if_id_load`=1, pc←pc+4.
  5. Otherwise: pc held, `if_id_load`=0.
- DISCARD: `imem_req`=1 and `imem_addr` held at the old pc; the protocol forbids changing the address while a request is outstanding. `if_id_load`=0.
  - A new `branch_taken` or `jump` overwrites pending_target, with branch priority, and raises `if_flush`=1.
  - When `imem_ready`=1, the data is dropped, pc←pending_target, and the next state is FETCH.
- `if_instruction`=`NOP_INSTR` whenever `if_id_load`=0.
- `if_flush` is asserted only in the redirect cycle and is never asserted together with `if_id_load`.
- Arithmetic:
  - pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Target bits [1:0] are forced to 0.
  - pc[1:0] is always 0.

## Timing
- All registers update on the posedge of `clock`; reset acts asynchronously.
- Outputs are combinational from state, `imem_ready`/`imem_rdata` and the redirect inputs. They are stable before the IF/ID register's negedge capture within the same cycle.
- Zero-wait memory (`imem_ready`=1 every cycle): one instruction per cycle. The first valid `if_id_load` occurs in the second cycle after reset release.
- Redirect penalty with a ready memory is one cycle: the target is fetched the cycle after `branch_taken`/`jump`.
- Redirect during a wait costs at least one extra cycle: the outstanding response is awaited and discarded.
- Handshake: once `imem_req`=1, `imem_addr` stays constant until a posedge with `imem_ready`=1. `imem_ready` while `imem_req`=0 is ignored.

## Test plan
- Reset and stream: release reset with `imem_ready`=1.
  - Cycle 1: `imem_req`=0.
  - Then `if_pc`=0,4,8,… with `if_id_load`=1 each cycle and `if_instruction`=`imem_rdata`.
- Stall: assert `stall` for 2 cycles at pc=0x10 -> `if_id_load`=0 and `imem_addr` stays 0x10; after release, 0x10 is loaded, then 0x14.
- Branch and simultaneous events:
  - `branch_taken`=1 with target 0x200 and `jump`=1 with target 0x300 in the same cycle, plus `stall`=1 -> `if_flush`=1 and `if_id_load`=0; the next fetch address is 0x200.
  - `branch_taken` with target 0x203 -> next fetch address is 0x200.
- Redirect while waiting:
  - `imem_ready`=0 at pc=0x40, then `jump` with target 0x80 -> `imem_addr` holds 0x40.
  - 3 cycles later, `imem_ready`=1 -> the data is not loaded; next cycle `imem_addr`=0x80.
- Wrap: start at `RESET_PC`=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-wait: drop `reset` while in DISCARD -> `imem_req`=0 and `if_flush`=0 immediately; after release, the fetch restarts at `RESET_PC` after one idle cycle.
